muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer for the RV32M ops, sitting beside the EX-stage ALU.
- Accepts one operation on the post-forwarding operands (the same readData1/readData2 values the ALU sees) and runs a one-bit-per-cycle shift-add multiply or restoring divide.
- Holds the pipeline stall while busy and presents the 32-bit result for the EX/MEM register on a one-cycle done pulse.

---
 rtl/muldiv_if.sv | 13 +
 rtl/muldiv_seq.sv | 91 +++++++++
 tb/tb_muldiv_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the EX stage and the mul/div sequencer
interface muldiv_if #(parameter int W = 32);
    logic         start;
    logic [2:0]   funct3;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         flush;
    logic         stall;
    logic         done;
    logic [W-1:0] result;
    modport master (output start, funct3, op_a, op_b, flush, input stall, done, result);
    modport slave  (input start, funct3, op_a, op_b, flush, output stall, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: one-bit-per-cycle RV32M multiply/divide sequencer with pipeline stall
module muldiv_seq #(
    parameter int WORD_BITWIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    muldiv_if.slave  bus
);
    localparam int W  = WORD_BITWIDTH;
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t          state_q, state_d;
    logic [2:0]      f_q, f_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d, div0_q, div0_d;
    logic            accept, signed_a, signed_b, sa, sb, ge;
    logic [W:0]      mul_sum, rem_sh;
    logic [W-1:0]    rem_sub, quo, rem, fix_val;
    logic [2*W-1:0]  prod;
    assign accept   = state_q == IDLE && bus.start && !bus.flush;
    assign signed_a = bus.funct3 == 3'b001 || bus.funct3 == 3'b010 || bus.funct3 == 3'b100 || bus.funct3 == 3'b110;
    assign signed_b = bus.funct3 == 3'b001 || bus.funct3 == 3'b100 || bus.funct3 == 3'b110;
    assign sa       = bus.op_a[W-1] && signed_a;
    assign sb       = bus.op_b[W-1] && signed_b;
    // a_q/b_q hold multiplicand/multiplier for MUL*, dividend/divisor for DIV*/REM*
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, b_q[0] ? a_q : {W{1'b0}}};
    assign rem_sh   = {acc_q[2*W-1:W], a_q[W-1]};
    assign ge       = rem_sh >= {1'b0, b_q};
    assign rem_sub  = rem_sh[W-1:0] - b_q;
    assign prod     = neg_q ? -acc_q : acc_q;
    assign quo      = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem      = neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    // divide-by-zero remainder falls out as the dividend; only the quotient needs forcing
    assign fix_val  = !f_q[2] ? (f_q[1:0] == 2'b00 ? prod[W-1:0] : prod[2*W-1:W]) :
                      f_q[1] ? rem : (div0_q ? {W{1'b1}} : quo);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            f_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f_q      <= f_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            result_q <= result_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? CALC : IDLE;
            CALC:    state_d = bus.flush ? IDLE : (cnt_q == CW'(W - 1) ? FIX : CALC);
            FIX:     state_d = bus.flush ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        bus.stall  = accept || state_q == CALC || state_q == FIX;
        bus.done   = state_q == DONE;
        bus.result = result_q;
    end
    always_comb begin
        f_d      = accept ? bus.funct3 : f_q;
        a_d      = accept ? (sa ? -bus.op_a : bus.op_a) : a_q;
        b_d      = accept ? (sb ? -bus.op_b : bus.op_b) : b_q;
        neg_d    = accept ? (bus.funct3[2] && bus.funct3[1] ? sa : sa ^ sb) : neg_q;
        div0_d   = accept ? bus.op_b == '0 : div0_q;
        acc_d    = accept ? '0 : acc_q;
        cnt_d    = accept ? '0 : cnt_q;
        result_d = state_q == FIX && !bus.flush ? fix_val : result_q;
        if (state_q == CALC) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = !f_q[2] ? {mul_sum, acc_q[W-1:1]} : {ge ? rem_sub : rem_sh[W-1:0], acc_q[W-2:0], ge};
            b_d   = !f_q[2] ? b_q >> 1 : b_q;
            a_d   = f_q[2] ? a_q << 1 : a_q;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table, corner-sequence and random checks of muldiv_seq against an arithmetic model
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    muldiv_if #(.W(32)) m ();
    muldiv_seq #(.WORD_BITWIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(m));
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_res = '0;
    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[12];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin p = sa / sb; return b == 0 ? 32'hFFFF_FFFF : p[31:0]; end
            3'd5: begin p = ua / ub; return b == 0 ? 32'hFFFF_FFFF : p[31:0]; end
            3'd6: begin p = sa % sb; return b == 0 ? a : p[31:0]; end
            default: begin p = ua % ub; return b == 0 ? a : p[31:0]; end
        endcase
    endfunction
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input bit fl_done, output logic [31:0] res, output int lat);
        bit busy_ok = 1'b1;
        @(posedge clk);
        #1 m.start = 1'b1; m.funct3 = f; m.op_a = a; m.op_b = b; m.flush = 1'b0;
        @(negedge clk);
        if (!m.stall) busy_ok = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(posedge clk);
            #1 m.start = hold;
            if (hold) begin
                m.op_a = $urandom;
                m.funct3 = 3'($urandom);
            end
            m.flush = fl_done && c == 34;
            @(negedge clk);
            if (m.done) begin
                lat = c;
                if (m.stall) busy_ok = 1'b0;
                m.start = 1'b0;
                m.flush = 1'b0;
            end else if (!m.stall) busy_ok = 1'b0;
        end
        res = m.result;
        chk("stall_while_busy", 32'(busy_ok), 32'd1);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [31:0] res, a, b;
        logic [2:0] f;
        int lat;
        bit no_done;
        m.start = 1'b0; m.flush = 1'b0; m.funct3 = '0; m.op_a = '0; m.op_b = '0;
        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        tbl[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        tbl[6]  = '{3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF};
        tbl[7]  = '{3'd7, 32'd100,       32'd0,         32'd100};
        tbl[8]  = '{3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF};
        tbl[9]  = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
        tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 32'(m.stall), 32'd0);
        chk("reset_done", 32'(m.done), 32'd0);
        chk("reset_result", m.result, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        foreach (tbl[i]) begin
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, 1'b0, 1'b0, res, lat);
            chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd34);
            last_res = tbl[i].exp;
        end
        // start together with flush is refused
        @(posedge clk);
        #1 m.start = 1'b1; m.flush = 1'b1; m.funct3 = 3'd0; m.op_a = 32'd2; m.op_b = 32'd3;
        @(negedge clk);
        chk("start_flush_stall", 32'(m.stall), 32'd0);
        no_done = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1 m.start = 1'b0; m.flush = 1'b0;
            @(negedge clk);
            if (m.done || m.stall) no_done = 1'b0;
        end
        chk("start_flush_ignored", 32'(no_done), 32'd1);
        chk("start_flush_result", m.result, last_res);
        // flush in CALC aborts DIVU, then MUL 3*5 starts in cycle 12
        @(posedge clk);
        #1 m.start = 1'b1; m.funct3 = 3'd5; m.op_a = 32'd100; m.op_b = 32'd7;
        no_done = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk);
            #1 m.start = 1'b0; m.flush = c == 10;
            @(negedge clk);
            if (m.done) no_done = 1'b0;
            if (c == 10) chk("abort_stall_c10", 32'(m.stall), 32'd1);
        end
        chk("abort_stall_c11", 32'(m.stall), 32'd0);
        chk("abort_no_done", 32'(no_done), 32'd1);
        chk("abort_result_kept", m.result, last_res);
        run_op(3'd0, 32'd3, 32'd5, 1'b0, 1'b0, res, lat);
        chk("after_abort_result", res, 32'd15);
        chk("after_abort_latency", 32'(lat + 12), 32'd46);
        // synchronous reset in cycle 20 of a MULHU
        @(posedge clk);
        #1 m.start = 1'b1; m.funct3 = 3'd3; m.op_a = $urandom; m.op_b = $urandom;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1 m.start = 1'b0;
            if (c == 20) rst_n = 1'b0;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_stall", 32'(m.stall), 32'd0);
        chk("midreset_done", 32'(m.done), 32'd0);
        chk("midreset_result", m.result, 32'd0);
        no_done = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m.done) no_done = 1'b0;
        end
        chk("midreset_no_done", 32'(no_done), 32'd1);
        // start held high while busy and flush during DONE
        a = $urandom; b = $urandom;
        run_op(3'd1, a, b, 1'b1, 1'b1, res, lat);
        chk("held_start_result", res, model(3'd1, a, b));
        chk("held_start_latency", 32'(lat), 32'd34);
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 7) == 0 ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(f, a, b, 1'b0, 1'b0, res, lat);
            chk($sformatf("rand%0d_f%0d_%h_%h", i, f, a, b), res, model(f, a, b));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'd34);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
